programmable_window_detector: RTL and testbench

Runtime-programmable sliding-window serial sequence detector, the parametrised successor to the fixed-pattern detector FSM. It accepts one bit per valid cycle and compares the last cfg_len bits against a loaded pattern. It asserts a Mealy-style dec pulse on each match, supports overlapping and non-overlapping detection, and keeps a saturating match counter. It sits between the serial input sampler and the lab display/LED logic.

---
 rtl/programmable_window_detector.sv | 194 +++++++++++++++++++
 tb/tb_programmable_window_detector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/programmable_window_detector.sv
// -----------------------------------------------------------------------------
// programmable_window_detector
//
// Purpose:
//   Runtime-programmable sliding-window serial sequence detector. One bit is
//   taken per valid cycle and the most recent len bits are compared against a
//   loaded pattern. A Mealy-style dec pulse flags each match in the same cycle
//   as the completing bit. Detection may be overlapping or non-overlapping. A
//   saturating counter tallies matches.
//
// Optional feature (compile-time macro PWD_DONT_CARE_MASK_EN):
//   Adds cfg_mask, loaded together with the pattern. A 0 in the mask marks a
//   don't-care position in the compare. The mask resets to all ones.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   cfg_we       in   load cfg_pattern / cfg_len / cfg_overlap (and cfg_mask)
//   cfg_pattern  in   pattern, right-aligned, bit[len-1] is received first
//   cfg_len      in   pattern length (clamped to MAX_LEN, 0 disables)
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   cfg_mask     in   (PWD_DONT_CARE_MASK_EN only) per-position compare enable
//   in_valid     in   in carries a valid bit this cycle
//   in           in   serial data bit
//   cnt_clr      in   clear match_cnt (wins over a coincident match)
//   dec          out  match on the current valid bit (combinational)
//   match_cnt    out  saturating match count (registered)
//   armed        out  window holds at least len-1 bits (registered)
// -----------------------------------------------------------------------------
module programmable_window_detector #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = 4,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1110,
    parameter logic [LEN_W-1:0]   RST_LEN     = 4'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef PWD_DONT_CARE_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               in_valid,
    input  logic               in,
    input  logic               cnt_clr,
    output logic               dec,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [LEN_W:0]   ONE_EXT   = {{LEN_W{1'b0}}, 1'b1};

    // Configuration registers
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
`ifdef PWD_DONT_CARE_MASK_EN
    logic [MAX_LEN-1:0] mask_q, mask_d;
`endif

    // Detection state. Only MAX_LEN-1 previous bits are ever compared (the
    // newest bit comes straight from the input), so the history keeps that many.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;

    // Combinational helpers
    logic               accept_s;
    logic [MAX_LEN-1:0] win_s;
    logic [MAX_LEN-1:0] len_mask_s;
    logic [MAX_LEN-1:0] cmp_mask_s;
    logic [MAX_LEN-1:0] diff_s;
    logic               filled_s;
    logic               match_s;
    logic [LEN_W-1:0]   cfg_len_clamped_s;
    logic [LEN_W-1:0]   fill_inc_s;

    // Window compare and Mealy match decision for the current input bit
    always_comb begin
        accept_s = in_valid & ~cfg_we;
        win_s    = {hist_q, in};
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask_s[i] = (i < int'(len_q));
        end
`ifdef PWD_DONT_CARE_MASK_EN
        cmp_mask_s = len_mask_s & mask_q;
`else
        cmp_mask_s = len_mask_s;
`endif
        diff_s   = (win_s ^ pattern_q) & cmp_mask_s;
        // fill >= len-1, written as fill+1 >= len to stay safe when len is 0
        filled_s = (({1'b0, fill_q} + ONE_EXT) >= {1'b0, len_q});
        // rst_n gates the pulse so nothing fires during a reset cycle
        match_s  = rst_n & accept_s & (len_q != {LEN_W{1'b0}}) & filled_s &
                   (diff_s == {MAX_LEN{1'b0}});
    end

    // Next-state computation for configuration, window, fill and counter
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
`ifdef PWD_DONT_CARE_MASK_EN
        mask_d    = mask_q;
`endif
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;

        if (cfg_len > MAX_LEN_C) begin
            cfg_len_clamped_s = MAX_LEN_C;
        end else begin
            cfg_len_clamped_s = cfg_len;
        end

        if (fill_q < len_q) begin
            fill_inc_s = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            fill_inc_s = len_q;
        end

        if (cfg_we) begin
            // New configuration starts from an empty window; the input bit is dropped
            pattern_d = cfg_pattern;
            len_d     = cfg_len_clamped_s;
            overlap_d = cfg_overlap;
`ifdef PWD_DONT_CARE_MASK_EN
            mask_d    = cfg_mask;
`endif
            hist_d    = {(MAX_LEN-1){1'b0}};
            fill_d    = {LEN_W{1'b0}};
        end else if (accept_s) begin
            hist_d = win_s[MAX_LEN-2:0];
            if (match_s && !overlap_q) begin
                // Non-overlapping: the next match needs a fully fresh window
                fill_d = {LEN_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end

        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (match_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        armed_d = (len_d != {LEN_W{1'b0}}) &&
                  (({1'b0, fill_d} + ONE_EXT) >= {1'b0, len_d});
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN;
            overlap_q <= 1'b1;
`ifdef PWD_DONT_CARE_MASK_EN
            mask_q    <= {MAX_LEN{1'b1}};
`endif
            hist_q    <= {(MAX_LEN-1){1'b0}};
            fill_q    <= {LEN_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            armed_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
`ifdef PWD_DONT_CARE_MASK_EN
            mask_q    <= mask_d;
`endif
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
        end
    end

    assign dec       = match_s;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_programmable_window_detector.sv
module tb_programmable_window_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_SAT = 3;

    logic               clk;
    logic               rst_n;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [MAX_LEN-1:0] cfg_mask;
    logic               in_valid;
    logic               in_s;
    logic               cnt_clr;
    logic               dec;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: bits accepted since the last window clear
    int                 m_q[$];
    logic [MAX_LEN-1:0] m_pat;
    logic [MAX_LEN-1:0] m_mask;
    int                 m_len;
    logic               m_ovl;
    int                 m_cnt;

    logic obs_dec, exp_dec, obs_armed, exp_armed;
    int   obs_cnt, exp_cnt;

    programmable_window_detector #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .RST_PATTERN(8'b0000_1110), .RST_LEN(4'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef PWD_DONT_CARE_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .in_valid(in_valid), .in(in_s), .cnt_clr(cnt_clr),
        .dec(dec), .match_cnt(match_cnt), .armed(armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Does the newest len bits (prior accepted bits plus b) equal the pattern?
    function automatic logic model_match(input logic b);
        int bv;
        if (m_len == 0) return 1'b0;
        if (m_q.size() + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            bv = (k == 0) ? int'(b) : m_q[m_q.size() - k];
            if (m_mask[k] && (bv != int'(m_pat[k]))) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: drive, sample dec mid-cycle, clock, sample registered outputs, advance model
    task automatic tick(input logic v, input logic b, input logic we, input logic clr, input logic rn);
        in_valid = v; in_s = b; cfg_we = we; cnt_clr = clr; rst_n = rn;
        #2;
        obs_dec = dec;
        exp_dec = (rn && !we && v) ? model_match(b) : 1'b0;
        @(posedge clk);
        #1;
        obs_cnt   = int'(match_cnt);
        obs_armed = armed;
        if (!rn) begin
            m_pat = 8'b0000_1110; m_len = 4; m_ovl = 1'b1; m_mask = 8'hFF;
            m_q.delete(); m_cnt = 0;
        end else begin
            if (we) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_ovl = cfg_overlap;
`ifdef PWD_DONT_CARE_MASK_EN
                m_mask = cfg_mask;
`else
                m_mask = 8'hFF;
`endif
                m_q.delete();
            end else if (v) begin
                m_q.push_back(int'(b));
                if (exp_dec && !m_ovl) m_q.delete();
                if (m_q.size() > 20) void'(m_q.pop_front());
            end
            if (clr) m_cnt = 0;
            else if (exp_dec && m_cnt < CNT_SAT) m_cnt++;
        end
        exp_cnt   = m_cnt;
        exp_armed = (m_len != 0) && (m_q.size() >= m_len - 1);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic clr);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_mask = 8'hFF;
        tick(1'b1, 1'b1, 1'b1, clr, 1'b1);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_dec !== 1'b0) begin n_err++; $display("FAIL reset_dec: got %b want 0", obs_dec); end
        n_cmp++; if (obs_cnt !== 0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", obs_cnt); end
        n_cmp++; if (obs_armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0", obs_armed); end
    endtask

    task automatic test_default();
        logic [3:0] s1;
        logic [4:0] s2;
        logic [7:0] dv;
        s1 = 4'b1110; s2 = 5'b11110; dv = 8'h00;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, s1[3-i], 1'b0, 1'b0, 1'b1);
            dv[i] = obs_dec;
            n_cmp++; if (obs_dec !== exp_dec) begin n_err++; $display("FAIL default_dec[%0d]: got %b want %b", i, obs_dec, exp_dec); end
            n_cmp++; if (obs_armed !== exp_armed) begin n_err++; $display("FAIL default_armed[%0d]: got %b want %b", i, obs_armed, exp_armed); end
        end
        n_cmp++; if (dv[3:0] !== 4'b1000) begin n_err++; $display("FAIL default_pulses1: got %b want 1000", dv[3:0]); end
        n_cmp++; if (obs_cnt !== 1) begin n_err++; $display("FAIL default_cnt1: got %0d want 1", obs_cnt); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, s2[4-i], 1'b0, 1'b0, 1'b1);
            dv[i] = obs_dec;
            n_cmp++; if (obs_dec !== exp_dec) begin n_err++; $display("FAIL default2_dec[%0d]: got %b want %b", i, obs_dec, exp_dec); end
        end
        n_cmp++; if (dv[4:0] !== 5'b10000) begin n_err++; $display("FAIL default_pulses2: got %b want 10000", dv[4:0]); end
        n_cmp++; if (obs_cnt !== 2) begin n_err++; $display("FAIL default_cnt2: got %0d want 2", obs_cnt); end
    endtask

    task automatic test_overlap();
        logic [4:0] s;
        logic [4:0] dv;
        s = 5'b10101;
        for (int m = 0; m < 2; m++) begin
            dv = 5'b00000;
            cfg(8'b0000_0101, 4'd3, (m == 0), 1'b1);
            for (int i = 0; i < 5; i++) begin
                tick(1'b1, s[4-i], 1'b0, 1'b0, 1'b1);
                dv[i] = obs_dec;
                n_cmp++; if (obs_dec !== exp_dec) begin n_err++; $display("FAIL overlap%0d_dec[%0d]: got %b want %b", m, i, obs_dec, exp_dec); end
                n_cmp++; if (obs_armed !== exp_armed) begin n_err++; $display("FAIL overlap%0d_armed[%0d]: got %b want %b", m, i, obs_armed, exp_armed); end
            end
            n_cmp++; if (dv !== ((m == 0) ? 5'b10100 : 5'b00100)) begin n_err++; $display("FAIL overlap%0d_pulses: got %b", m, dv); end
            n_cmp++; if (obs_cnt !== ((m == 0) ? 2 : 1)) begin n_err++; $display("FAIL overlap%0d_cnt: got %0d want %0d", m, obs_cnt, (m == 0) ? 2 : 1); end
        end
    endtask

    task automatic test_gaps();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, i[0], 1'b0, 1'b0, 1'b1);
            n_cmp++; if (obs_dec !== 1'b0) begin n_err++; $display("FAIL gap_dec[%0d]: got %b want 0", i, obs_dec); end
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (obs_dec !== 1'b1 || exp_dec !== 1'b1) begin n_err++; $display("FAIL gap_final_dec: got %b want 1", obs_dec); end
        n_cmp++; if (obs_cnt !== exp_cnt) begin n_err++; $display("FAIL gap_cnt: got %0d want %0d", obs_cnt, exp_cnt); end
    endtask

    task automatic test_config_mid();
        logic [4:0] s;
        s = 5'b00110;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cfg(8'b0000_0110, 4'd4, 1'b1, 1'b0);
        n_cmp++; if (obs_dec !== 1'b0) begin n_err++; $display("FAIL cfgmid_we_dec: got %b want 0", obs_dec); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, s[4-i], 1'b0, 1'b0, 1'b1);
            n_cmp++; if (obs_dec !== exp_dec || obs_dec !== (i == 4)) begin n_err++; $display("FAIL cfgmid_dec[%0d]: got %b want %b", i, obs_dec, (i == 4)); end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] s;
        s = 4'b1110;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) tick(1'b1, s[3-i], 1'b0, (r == 5 && i == 3), 1'b1);
            n_cmp++; if (obs_dec !== 1'b1) begin n_err++; $display("FAIL sat_dec[%0d]: got %b want 1", r, obs_dec); end
            n_cmp++; if (obs_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", r, obs_cnt, exp_cnt); end
            if (r == 4) begin
                n_cmp++; if (obs_cnt !== 3) begin n_err++; $display("FAIL sat_cnt_max: got %0d want 3", obs_cnt); end
            end
        end
        n_cmp++; if (obs_cnt !== 0) begin n_err++; $display("FAIL sat_clr: got %0d want 0", obs_cnt); end
    endtask

    task automatic test_reset_mid_and_len();
        logic [7:0] p;
        p = 8'b1010_0101;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (obs_dec !== 1'b0) begin n_err++; $display("FAIL rstmid_dec: got %b want 0", obs_dec); end
        cfg(8'h00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++; if (obs_dec !== 1'b0 || obs_armed !== 1'b0) begin n_err++; $display("FAIL len0[%0d]: got dec %b armed %b want 0 0", i, obs_dec, obs_armed); end
        end
        cfg(p, 4'd12, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, p[7-i], 1'b0, 1'b0, 1'b1);
            n_cmp++; if (obs_dec !== exp_dec || obs_dec !== (i == 7)) begin n_err++; $display("FAIL len12_dec[%0d]: got %b want %b", i, obs_dec, (i == 7)); end
            n_cmp++; if (obs_armed !== (i >= 6)) begin n_err++; $display("FAIL len12_armed[%0d]: got %b want %b", i, obs_armed, (i >= 6)); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                tick(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
            end else if (r < 6) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom);
                cfg_mask    = 8'($urandom);
                tick(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b1);
            end else begin
                tick(($urandom_range(0, 9) < 7), 1'($urandom), 1'b0, ($urandom_range(0, 39) == 0), 1'b1);
            end
            n_cmp++; if (obs_dec !== exp_dec) begin n_err++; $display("FAIL rand_dec[%0d]: got %b want %b", n, obs_dec, exp_dec); end
            n_cmp++; if (obs_cnt !== exp_cnt) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, obs_cnt, exp_cnt); end
            n_cmp++; if (obs_armed !== exp_armed) begin n_err++; $display("FAIL rand_armed[%0d]: got %b want %b", n, obs_armed, exp_armed); end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
        cfg_overlap = 1'b0; cfg_mask = 8'hFF; in_valid = 1'b0; in_s = 1'b0; cnt_clr = 1'b0;
        m_pat = 8'b0000_1110; m_len = 4; m_ovl = 1'b1; m_mask = 8'hFF; m_cnt = 0;
        test_reset();
        test_default();
        test_overlap();
        test_gaps();
        test_config_mid();
        test_saturation();
        test_reset_mid_and_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
